// File: rtl/vu_pkg.sv
// vu_pkg: op encodings and FSM state type shared by the vector unit files
package vu_pkg;

    localparam logic [1:0] VU_OP_LOAD  = 2'b00;
    localparam logic [1:0] VU_OP_STORE = 2'b01;
    localparam logic [1:0] VU_OP_ADD   = 2'b10;
    localparam logic [1:0] VU_OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPRD,
        S_LOAD,
        S_LCAP,
        S_STORE,
        S_EXEC,
        S_DONE
    } vu_state_e;

endpackage

// File: rtl/vector_unit_if.sv
// vector_unit_if: start/done handshake, memory beat bus and debug read port of the vector unit
interface vector_unit_if #(
    parameter int LANES = 4,
    parameter int LW    = 8,
    parameter int NVREG = 4,
    parameter int AW    = 8
);
    localparam int VW = $clog2(NVREG);

    logic                  start;
    logic [1:0]            op;
    logic [VW-1:0]         vd;
    logic [VW-1:0]         vs;
    logic [AW-1:0]         base_addr;
    logic                  busy;
    logic                  done;
    logic                  illegal;
    logic [AW-1:0]         next_addr;
    logic [AW-1:0]         mem_addr;
    logic                  mem_rden;
    logic                  mem_wren;
    logic [LW-1:0]         mem_wdata;
    logic [LW-1:0]         mem_rdata;
    logic [VW-1:0]         dbg_sel;
    logic [LANES*LW-1:0]   dbg_data;

    modport master (
        output start, op, vd, vs, base_addr, mem_rdata, dbg_sel,
        input  busy, done, illegal, next_addr, mem_addr, mem_rden, mem_wren, mem_wdata, dbg_data
    );

    modport slave (
        input  start, op, vd, vs, base_addr, mem_rdata, dbg_sel,
        output busy, done, illegal, next_addr, mem_addr, mem_rden, mem_wren, mem_wdata, dbg_data
    );

endinterface

// File: rtl/vu_vrf.sv
// vu_vrf: vector register file with two operand read ports, a debug read port and one write port
module vu_vrf #(
    parameter int LANES = 4,
    parameter int LW    = 8,
    parameter int NVREG = 4,
    localparam int VW   = $clog2(NVREG),
    localparam int DW   = LANES * LW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [VW-1:0] ra_sel,
    input  logic [VW-1:0] rb_sel,
    input  logic [VW-1:0] dbg_sel,
    output logic [DW-1:0] ra_data,
    output logic [DW-1:0] rb_data,
    output logic [DW-1:0] dbg_data,
    input  logic          we,
    input  logic [VW-1:0] wsel,
    input  logic [DW-1:0] wdata
);

    logic [DW-1:0] regs [NVREG];

    // single synchronous write port, whole file cleared by reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NVREG; i++) regs[i] <= '0;
        end else if (we) begin
            regs[wsel] <= wdata;
        end
    end

    assign ra_data  = regs[ra_sel];
    assign rb_data  = regs[rb_sel];
    assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/vector_unit.sv
// vector_unit: VLOAD/VSTORE/VADD sequencer over a shared memory; VU_SATURATE_EN selects saturating VADD lanes
module vector_unit
    import vu_pkg::*;
#(
    parameter int LANES = 4,
    parameter int LW    = 8,
    parameter int NVREG = 4,
    parameter int AW    = 8
) (
    input  logic          clock,
    input  logic          reset,
    vector_unit_if.slave  bus
);

    localparam int VW = $clog2(NVREG);
    localparam int KW = (LANES > 1) ? $clog2(LANES) : 1;

    vu_state_e              state, state_n;
    logic [1:0]             op_q;
    logic [VW-1:0]          vd_q, vs_q;
    logic [AW-1:0]          base_q;
    logic [KW-1:0]          k;
    logic                   last;
    logic [LANES-1:0][LW-1:0] x1, x2, t, sum, ld_word, ra_data, rb_data;

    assign last = (k == KW'(LANES - 1));

    // VSTORE reads its source through port A so the store path always uses X1
    vu_vrf #(.LANES(LANES), .LW(LW), .NVREG(NVREG)) u_vrf (
        .clock    (clock),
        .reset    (reset),
        .ra_sel   ((op_q == VU_OP_STORE) ? vs_q : vd_q),
        .rb_sel   (vs_q),
        .dbg_sel  (bus.dbg_sel),
        .ra_data  (ra_data),
        .rb_data  (rb_data),
        .dbg_data (bus.dbg_data),
        .we       (state == S_LCAP || state == S_EXEC),
        .wsel     (vd_q),
        .wdata    ((state == S_LCAP) ? ld_word : sum)
    );

    for (genvar i = 0; i < LANES; i++) begin : g_lane
`ifdef VU_SATURATE_EN
        logic [LW:0] s;
        assign s      = {1'b0, x1[i]} + {1'b0, x2[i]};
        assign sum[i] = s[LW] ? '1 : s[LW-1:0];
`else
        assign sum[i] = x1[i] + x2[i];
`endif
    end

    // final load beat arrives during LCAP, so it is merged straight into the write data
    always_comb begin
        ld_word = t;
        ld_word[LANES-1] = bus.mem_rdata;
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    // FSM next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (bus.start) state_n = (bus.op == VU_OP_LOAD) ? S_LOAD :
                                              (bus.op == VU_OP_RSVD) ? S_DONE : S_OPRD;
            S_OPRD:  state_n = (op_q == VU_OP_STORE) ? S_STORE : S_EXEC;
            S_LOAD:  if (last) state_n = S_LCAP;
            S_LCAP:  state_n = S_DONE;
            S_STORE: if (last) state_n = S_DONE;
            S_EXEC:  state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // operand latches, lane counter and load gather register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q   <= '0;
            vd_q   <= '0;
            vs_q   <= '0;
            base_q <= '0;
            k      <= '0;
            x1     <= '0;
            x2     <= '0;
            t      <= '0;
        end else begin
            if (state == S_IDLE && bus.start) begin
                op_q   <= bus.op;
                vd_q   <= bus.vd;
                vs_q   <= bus.vs;
                base_q <= bus.base_addr;
                k      <= '0;
            end
            if (state == S_OPRD) begin
                x1 <= ra_data;
                x2 <= rb_data;
            end
            if (state == S_LOAD && k != '0) t[k - 1'b1] <= bus.mem_rdata;
            if (state == S_LCAP) t <= ld_word;
            if (state == S_LOAD || state == S_STORE) k <= last ? '0 : k + 1'b1;
        end
    end

    // FSM outputs; memory bus is idle (all zero) outside LOAD/STORE
    always_comb begin
        bus.busy      = (state != S_IDLE);
        bus.done      = (state == S_DONE);
        bus.illegal   = (state == S_DONE) && (op_q == VU_OP_RSVD);
        bus.mem_rden  = (state == S_LOAD);
        bus.mem_wren  = (state == S_STORE);
        bus.mem_addr  = (state == S_LOAD || state == S_STORE) ? base_q + AW'(k) : '0;
        bus.mem_wdata = (state == S_STORE) ? x1[k] : '0;
        bus.next_addr = (state != S_DONE) ? '0 :
                        (op_q == VU_OP_LOAD || op_q == VU_OP_STORE) ? base_q + AW'(LANES) : base_q;
    end

endmodule

// File: tb/tb_vector_unit.sv
// tb_vector_unit: directed checks of load/add/store, wrap, reset abort, busy start and a wide build
module tb_vector_unit;
    import vu_pkg::*;

    logic clock = 0;
    logic reset = 1;
    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    vector_unit_if #(.LANES(4), .LW(8), .NVREG(4), .AW(8)) bus ();
    vector_unit #(.LANES(4), .LW(8), .NVREG(4), .AW(8)) dut (.clock(clock), .reset(reset), .bus(bus));

    vector_unit_if #(.LANES(8), .LW(16), .NVREG(4), .AW(8)) wbus ();
    vector_unit #(.LANES(8), .LW(16), .NVREG(4), .AW(8)) wdut (.clock(clock), .reset(reset), .bus(wbus));

    logic [7:0]  mem  [256];
    logic [15:0] wmem [256];

`ifdef VU_SATURATE_EN
    localparam logic [31:0] ADD_EXP = 32'h45FF3191;
    localparam logic [31:0] DBL_EXP = 32'h02FF1EFF;
`else
    localparam logic [31:0] ADD_EXP = 32'h45323191;
    localparam logic [31:0] DBL_EXP = 32'h02FE1E00;
`endif

    always @(posedge clock) begin
        if (bus.mem_rden) bus.mem_rdata <= mem[bus.mem_addr];
        if (bus.mem_wren) mem[bus.mem_addr] <= bus.mem_wdata;
        if (wbus.mem_rden) wbus.mem_rdata <= wmem[wbus.mem_addr];
        if (wbus.mem_wren) wmem[wbus.mem_addr] <= wbus.mem_wdata;
    end

    task automatic run_op(input logic [1:0] op, input logic [1:0] vd, input logic [1:0] vs,
                          input logic [7:0] base, output int cyc);
        @(negedge clock);
        bus.start = 1; bus.op = op; bus.vd = vd; bus.vs = vs; bus.base_addr = base;
        @(negedge clock);
        bus.start = 0; bus.vd = ~vd; bus.vs = ~vs; bus.base_addr = ~base;
        cyc = 1;
        while (!bus.done && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic run_wop(input logic [1:0] op, input logic [1:0] vd, input logic [7:0] base,
                           output int cyc);
        @(negedge clock);
        wbus.start = 1; wbus.op = op; wbus.vd = vd; wbus.vs = vd; wbus.base_addr = base;
        @(negedge clock);
        wbus.start = 0; wbus.base_addr = ~base;
        cyc = 1;
        while (!wbus.done && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic test_reset;
        #2 reset = 0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b expected 0", bus.illegal); end
        checks++; if ({bus.mem_rden, bus.mem_wren} !== 2'b00) begin errors++; $display("FAIL reset_mem_en: got %b expected 00", {bus.mem_rden, bus.mem_wren}); end
        checks++; if ({bus.mem_addr, bus.mem_wdata, bus.next_addr} !== 24'h0) begin errors++; $display("FAIL reset_buses: got %h expected 000000", {bus.mem_addr, bus.mem_wdata, bus.next_addr}); end
        for (int i = 0; i < 4; i++) begin
            bus.dbg_sel = 2'(i);
            #1;
            checks++; if (bus.dbg_data !== 32'h0) begin errors++; $display("FAIL reset_vrf%0d: got %h expected 00000000", i, bus.dbg_data); end
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1;
    endtask

    task automatic test_vload;
        int cyc;
        mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
        bus.dbg_sel = 2'd1;
        run_op(VU_OP_LOAD, 2'd1, 2'd0, 8'h10, cyc);
        checks++; if (cyc !== 6) begin errors++; $display("FAIL vload_cycle: got %0d expected 6", cyc); end
        checks++; if (bus.dbg_data !== 32'h44332211) begin errors++; $display("FAIL vload_data: got %h expected 44332211", bus.dbg_data); end
        checks++; if (bus.next_addr !== 8'h14) begin errors++; $display("FAIL vload_next: got %h expected 14", bus.next_addr); end
        checks++; if ({bus.illegal, bus.mem_rden, bus.mem_addr} !== 10'h0) begin errors++; $display("FAIL vload_done_idle_bus: got %h expected 000", {bus.illegal, bus.mem_rden, bus.mem_addr}); end
        @(negedge clock);
        checks++; if ({bus.done, bus.busy} !== 2'b00) begin errors++; $display("FAIL vload_done_pulse: got %b expected 00", {bus.done, bus.busy}); end
    endtask

    task automatic test_vadd;
        int cyc;
        mem[8'h20] = 8'h80; mem[8'h21] = 8'h0F; mem[8'h22] = 8'hFF; mem[8'h23] = 8'h01;
        run_op(VU_OP_LOAD, 2'd2, 2'd0, 8'h20, cyc);
        bus.dbg_sel = 2'd1;
        run_op(VU_OP_ADD, 2'd1, 2'd2, 8'h33, cyc);
        checks++; if (cyc !== 3) begin errors++; $display("FAIL vadd_cycle: got %0d expected 3", cyc); end
        checks++; if (bus.dbg_data !== ADD_EXP) begin errors++; $display("FAIL vadd_data: got %h expected %h", bus.dbg_data, ADD_EXP); end
        checks++; if (bus.next_addr !== 8'h33) begin errors++; $display("FAIL vadd_next: got %h expected 33", bus.next_addr); end
        bus.dbg_sel = 2'd2;
        run_op(VU_OP_ADD, 2'd2, 2'd2, 8'h00, cyc);
        checks++; if (bus.dbg_data !== DBL_EXP) begin errors++; $display("FAIL vadd_self: got %h expected %h", bus.dbg_data, DBL_EXP); end
    endtask

    task automatic test_vstore;
        int cyc;
        mem[8'h30] = 8'hD4; mem[8'h31] = 8'hC3; mem[8'h32] = 8'hB2; mem[8'h33] = 8'hA1;
        run_op(VU_OP_LOAD, 2'd3, 2'd0, 8'h30, cyc);
        run_op(VU_OP_STORE, 2'd3, 2'd3, 8'hFE, cyc);
        checks++; if (cyc !== 6) begin errors++; $display("FAIL vstore_cycle: got %0d expected 6", cyc); end
        checks++; if (bus.next_addr !== 8'h02) begin errors++; $display("FAIL vstore_next: got %h expected 02", bus.next_addr); end
        checks++; if ({mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]} !== 32'hD4C3B2A1) begin errors++; $display("FAIL vstore_mem: got %h expected d4c3b2a1", {mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]}); end
        checks++; if (bus.mem_wren !== 1'b0) begin errors++; $display("FAIL vstore_wren_done: got %b expected 0", bus.mem_wren); end
    endtask

    task automatic test_reset_mid;
        int cyc;
        @(negedge clock);
        bus.start = 1; bus.op = VU_OP_LOAD; bus.vd = 2'd3; bus.base_addr = 8'h10;
        @(negedge clock);
        bus.start = 0;
        @(negedge clock);
        checks++; if (bus.mem_rden !== 1'b1) begin errors++; $display("FAIL rmid_rden_before: got %b expected 1", bus.mem_rden); end
        reset = 0;
        #1;
        checks++; if ({bus.busy, bus.mem_rden} !== 2'b00) begin errors++; $display("FAIL rmid_drop: got %b expected 00", {bus.busy, bus.mem_rden}); end
        bus.dbg_sel = 2'd3;
        #1;
        checks++; if (bus.dbg_data !== 32'h0) begin errors++; $display("FAIL rmid_v3: got %h expected 00000000", bus.dbg_data); end
        @(negedge clock);
        reset = 1;
        run_op(VU_OP_LOAD, 2'd3, 2'd0, 8'h10, cyc);
        checks++; if (cyc !== 6) begin errors++; $display("FAIL rmid_reload_cycle: got %0d expected 6", cyc); end
        checks++; if (bus.dbg_data !== 32'h44332211) begin errors++; $display("FAIL rmid_reload_data: got %h expected 44332211", bus.dbg_data); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        run_op(VU_OP_LOAD, 2'd1, 2'd0, 8'h10, cyc);
        run_op(VU_OP_LOAD, 2'd2, 2'd0, 8'h20, cyc);
        bus.dbg_sel = 2'd1;
        @(negedge clock);
        bus.start = 1; bus.op = VU_OP_ADD; bus.vd = 2'd1; bus.vs = 2'd2; bus.base_addr = 8'h5A;
        @(negedge clock);
        bus.op = VU_OP_RSVD;
        cyc = 1;
        while (!bus.done && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
        checks++; if (cyc !== 3) begin errors++; $display("FAIL b2b_add_cycle: got %0d expected 3", cyc); end
        checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL b2b_add_illegal: got %b expected 0", bus.illegal); end
        checks++; if (bus.dbg_data !== ADD_EXP) begin errors++; $display("FAIL b2b_add_data: got %h expected %h", bus.dbg_data, ADD_EXP); end
        @(negedge clock);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", bus.busy); end
        @(negedge clock);
        bus.start = 0;
        checks++; if ({bus.done, bus.illegal} !== 2'b11) begin errors++; $display("FAIL b2b_illegal: got %b expected 11", {bus.done, bus.illegal}); end
        checks++; if (bus.next_addr !== 8'h5A) begin errors++; $display("FAIL b2b_illegal_next: got %h expected 5a", bus.next_addr); end
        @(negedge clock);
        checks++; if ({bus.done, bus.busy} !== 2'b00) begin errors++; $display("FAIL b2b_end: got %b expected 00", {bus.done, bus.busy}); end
        checks++; if (bus.dbg_data !== ADD_EXP) begin errors++; $display("FAIL b2b_v1_kept: got %h expected %h", bus.dbg_data, ADD_EXP); end
        bus.dbg_sel = 2'd2;
        #1;
        checks++; if (bus.dbg_data !== 32'h01FF0F80) begin errors++; $display("FAIL b2b_v2_kept: got %h expected 01ff0f80", bus.dbg_data); end
    endtask

    task automatic test_wide;
        int cyc;
        logic [7:0] a;
        for (int j = 0; j < 8; j++) begin
            a = 8'hFC + 8'(j);
            wmem[a] = 16'h1001 * 16'(j + 1);
        end
        wbus.dbg_sel = 2'd0;
        run_wop(VU_OP_LOAD, 2'd0, 8'hFC, cyc);
        checks++; if (cyc !== 10) begin errors++; $display("FAIL wide_load_cycle: got %0d expected 10", cyc); end
        checks++; if (wbus.dbg_data !== 128'h8008_7007_6006_5005_4004_3003_2002_1001) begin errors++; $display("FAIL wide_load_data: got %h expected 80087007600650054004300320021001", wbus.dbg_data); end
        checks++; if (wbus.next_addr !== 8'h04) begin errors++; $display("FAIL wide_load_next: got %h expected 04", wbus.next_addr); end
        for (int j = 0; j < 8; j++) begin
            a = 8'hFC + 8'(j);
            wmem[a] = 16'h0;
        end
        run_wop(VU_OP_STORE, 2'd0, 8'hFC, cyc);
        checks++; if (cyc !== 10) begin errors++; $display("FAIL wide_store_cycle: got %0d expected 10", cyc); end
        checks++; if ({wmem[8'hFC], wmem[8'hFD], wmem[8'hFE], wmem[8'hFF], wmem[8'h00], wmem[8'h01], wmem[8'h02], wmem[8'h03]} !== 128'h1001_2002_3003_4004_5005_6006_7007_8008) begin
            errors++;
            $display("FAIL wide_store_mem: got %h expected 10012002300340045005600670078008", {wmem[8'hFC], wmem[8'hFD], wmem[8'hFE], wmem[8'hFF], wmem[8'h00], wmem[8'h01], wmem[8'h02], wmem[8'h03]});
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h0;
            wmem[i] = 16'h0;
        end
        bus.start = 0; bus.op = 0; bus.vd = 0; bus.vs = 0; bus.base_addr = 0; bus.dbg_sel = 0;
        wbus.start = 0; wbus.op = 0; wbus.vd = 0; wbus.vs = 0; wbus.base_addr = 0; wbus.dbg_sel = 0;
        test_reset;
        test_vload;
        test_vadd;
        test_vstore;
        test_reset_mid;
        test_back_to_back;
        test_wide;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
